// File: rtl/demo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demo_pkg
// Description : Shared types and constants for the demo scene sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package demo_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_IN  = 2'd1,
        RUN      = 2'd2,
        FADE_OUT = 2'd3
    } phase_t;

    localparam int         FADE_MAX    = 15;
    localparam logic [7:0] c_lfsr_taps = 8'hB8;
    localparam logic [7:0] c_lfsr_seed = 8'h01;

    // len_sel 0..3 selects 64, 128, 256 or 512 frames of RUN
    function automatic logic [9:0] scene_len(input logic [1:0] sel);
        return 10'd64 << sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : btn_sync_edge
// Description : Two-flop synchroniser with optional rising-edge pulse output.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_sync_edge #(
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ena,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else if (i_ena) begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

    generate
        if (EDGE_EN) begin : g_edge
            logic r_sync_d;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sync_d <= 1'b0;
                end else if (i_ena) begin
                    r_sync_d <= r_sync;
                end
            end

            assign o_rise = r_sync & ~r_sync_d;
        end else begin : g_no_edge
            assign o_rise = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/demo_scene_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : demo_scene_sequencer
// Description : Per-frame scene/fade scheduler; DEMO_SCENE_SHUFFLE_EN enables
//               LFSR-driven scene order instead of sequential.
// Revision    : 1.0 - initial release
// ============================================================================
module demo_scene_sequencer
    import demo_pkg::*;
#(
    parameter int NUM_SCENES = 4,
    parameter int FRAME_W    = 10,
    parameter int FADE_STEPS = FADE_MAX + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          frame_tick,
    input  logic                          btn_next,
    input  logic                          btn_pause,
    input  logic [1:0]                    len_sel,
    output logic [1:0]                    scene_id,
    output logic [FRAME_W-1:0]            scene_frame,
    output logic [$clog2(FADE_STEPS)-1:0] fade_level,
    output logic                          scene_start,
    output logic [1:0]                    phase
);

    localparam int                c_fade_w   = $clog2(FADE_STEPS);
    localparam logic [c_fade_w-1:0] c_fade_top = c_fade_w'(FADE_STEPS - 1);
    localparam logic [1:0]        c_last_scene = 2'(NUM_SCENES - 1);

    phase_t               r_state,       w_state_nxt;
    logic [1:0]           r_scene_id,    w_scene_id_nxt;
    logic [FRAME_W-1:0]   r_scene_frame, w_scene_frame_nxt;
    logic [FRAME_W-1:0]   r_scene_len,   w_scene_len_nxt;
    logic [c_fade_w-1:0]  r_fade,        w_fade_nxt;
    logic                 r_scene_start, w_scene_start_nxt;
    logic                 r_next_pend,   w_next_pend_nxt;

    logic w_next_rise;
    logic w_next_sync_unused;
    logic w_pause_sync;
    logic w_pause_rise_unused;
    logic w_tick;
    logic [1:0] w_seq_scene;
    logic [1:0] w_next_scene;

    btn_sync_edge #(.EDGE_EN(1'b1)) u_sync_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_ena   (ena),
        .i_async (btn_next),
        .o_sync  (w_next_sync_unused),
        .o_rise  (w_next_rise)
    );

    btn_sync_edge #(.EDGE_EN(1'b0)) u_sync_pause (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_ena   (ena),
        .i_async (btn_pause),
        .o_sync  (w_pause_sync),
        .o_rise  (w_pause_rise_unused)
    );

    // ena gating lives in the register process; here only tick and pause matter
    assign w_tick      = frame_tick & ~w_pause_sync;
    assign w_seq_scene = (r_scene_id == c_last_scene) ? 2'd0 : r_scene_id + 2'd1;

`ifdef DEMO_SCENE_SHUFFLE_EN
    logic [7:0] r_lfsr;
    logic [1:0] w_rand_scene;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= c_lfsr_seed;
        end else if (ena && w_tick) begin
            r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? c_lfsr_taps : 8'h00);
        end
    end

    assign w_rand_scene = 2'(int'(r_lfsr[1:0]) % NUM_SCENES);
    // A repeat of the current scene falls back to the sequential successor
    assign w_next_scene = (w_rand_scene == r_scene_id) ? w_seq_scene : w_rand_scene;
`else
    assign w_next_scene = w_seq_scene;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_scene_id    <= 2'd0;
            r_scene_frame <= '0;
            r_scene_len   <= '0;
            r_fade        <= '0;
            r_scene_start <= 1'b0;
            r_next_pend   <= 1'b0;
        end else if (ena) begin
            r_state       <= w_state_nxt;
            r_scene_id    <= w_scene_id_nxt;
            r_scene_frame <= w_scene_frame_nxt;
            r_scene_len   <= w_scene_len_nxt;
            r_fade        <= w_fade_nxt;
            r_scene_start <= w_scene_start_nxt;
            r_next_pend   <= w_next_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_scene_id_nxt    = r_scene_id;
        w_scene_frame_nxt = r_scene_frame;
        w_scene_len_nxt   = r_scene_len;
        w_fade_nxt        = r_fade;
        w_scene_start_nxt = 1'b0;
        w_next_pend_nxt   = r_next_pend | w_next_rise;

        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    w_state_nxt       = FADE_IN;
                    w_scene_start_nxt = 1'b1;
                    w_scene_len_nxt   = FRAME_W'(scene_len(len_sel));
                end
                FADE_IN: begin
                    if (r_next_pend) begin
                        w_state_nxt     = FADE_OUT;
                        w_next_pend_nxt = w_next_rise;
                    end else begin
                        w_fade_nxt = r_fade + c_fade_w'(1);
                        if (r_fade == c_fade_top - c_fade_w'(1)) begin
                            w_state_nxt       = RUN;
                            w_scene_frame_nxt = '0;
                        end
                    end
                end
                RUN: begin
                    w_fade_nxt = c_fade_top;
                    // The exit tick does not count, so scene_frame tops out at scene_len-1
                    if (r_next_pend || (r_scene_frame == r_scene_len - FRAME_W'(1))) begin
                        w_state_nxt     = FADE_OUT;
                        w_next_pend_nxt = w_next_rise;
                    end else begin
                        w_scene_frame_nxt = r_scene_frame + FRAME_W'(1);
                    end
                end
                FADE_OUT: begin
                    w_next_pend_nxt = w_next_rise;
                    if (r_fade <= c_fade_w'(1)) begin
                        w_fade_nxt        = '0;
                        w_state_nxt       = FADE_IN;
                        w_scene_id_nxt    = w_next_scene;
                        w_scene_frame_nxt = '0;
                        w_scene_start_nxt = 1'b1;
                        w_scene_len_nxt   = FRAME_W'(scene_len(len_sel));
                    end else begin
                        w_fade_nxt = r_fade - c_fade_w'(1);
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign scene_id    = r_scene_id;
    assign scene_frame = r_scene_frame;
    assign fade_level  = r_fade;
    assign scene_start = r_scene_start;
    assign phase       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_demo_scene_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_demo_scene_sequencer
// Description : Directed self-checking bench for demo_scene_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demo_scene_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       frame_tick;
    logic       btn_next;
    logic       btn_pause;
    logic [1:0] len_sel;
    logic [1:0] scene_id;
    logic [9:0] scene_frame;
    logic [3:0] fade_level;
    logic       scene_start;
    logic [1:0] phase;

    int n_checks = 0;
    int n_pass   = 0;

    demo_scene_sequencer #(
        .NUM_SCENES (4),
        .FRAME_W    (10),
        .FADE_STEPS (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .frame_tick  (frame_tick),
        .btn_next    (btn_next),
        .btn_pause   (btn_pause),
        .len_sel     (len_sel),
        .scene_id    (scene_id),
        .scene_frame (scene_frame),
        .fade_level  (fade_level),
        .scene_start (scene_start),
        .phase       (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the tick is taken
    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_next();
        btn_next = 1'b1;
        repeat (4) @(negedge clk);
        btn_next = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        frame_tick = 1'b0;
        btn_next   = 1'b0;
        btn_pause  = 1'b0;
        len_sel    = 2'd0;
        repeat (3) @(negedge clk);

        check("rst_phase", phase, 0);
        check("rst_scene", scene_id, 0);
        check("rst_frame", scene_frame, 0);
        check("rst_fade",  fade_level, 0);
        check("rst_start", scene_start, 0);
        tick();
        check("rst_tick_ignored", phase, 0);

        rst_n = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        tick();
        check("ena_low_tick_lost", phase, 0);
        ena = 1'b1;
        @(negedge clk);

        // Scene 0: IDLE -> FADE_IN, then 15 more ticks up to full brightness
        tick();
        check("first_start", scene_start, 1);
        check("first_phase", phase, 1);
        check("first_fade",  fade_level, 0);
        @(negedge clk);
        check("start_one_cycle", scene_start, 0);
        for (int k = 2; k <= 16; k++) begin
            tick();
            check("fade_in_level", fade_level, k - 1);
            check("fade_in_phase", phase, (k == 16) ? 2 : 1);
        end
        check("run_frame0", scene_frame, 0);

        for (int k = 1; k <= 63; k++) begin
            tick();
            check("run_frame", scene_frame, k);
        end
        check("run_phase63", phase, 2);
        tick();
        check("len_end_phase", phase, 3);
        check("len_end_frame", scene_frame, 63);
        check("len_end_fade",  fade_level, 15);
        for (int k = 1; k <= 15; k++) begin
            tick();
            check("fade_out_level", fade_level, 15 - k);
        end
        check("adv_phase", phase, 1);
        check("adv_scene", scene_id, 1);
        check("adv_start", scene_start, 1);
        check("adv_frame", scene_frame, 0);

        // Scene 1: skip via btn_next at scene_frame 10
        ticks(15);
        check("s1_run", phase, 2);
        check("s1_fade", fade_level, 15);
        ticks(10);
        check("s1_frame10", scene_frame, 10);
        btn_next = 1'b1;
        tick();
        check("skip_not_early_phase", phase, 2);
        check("skip_not_early_frame", scene_frame, 11);
        repeat (3) @(negedge clk);
        btn_next = 1'b0;
        tick();
        check("skip_phase", phase, 3);
        check("skip_frame", scene_frame, 11);
        check("skip_fade",  fade_level, 15);
        ticks(15);
        check("s2_scene", scene_id, 2);
        check("s2_phase", phase, 1);

        // Scene 2: pause holds everything and keeps the pending skip
        ticks(20);
        check("s2_frame5", scene_frame, 5);
        btn_pause = 1'b1;
        repeat (3) @(negedge clk);
        press_next();
        for (int k = 0; k < 20; k++) begin
            tick();
            check("pause_phase", phase, 2);
        end
        check("pause_frame", scene_frame, 5);
        check("pause_fade",  fade_level, 15);
        check("pause_scene", scene_id, 2);
        btn_pause = 1'b0;
        repeat (3) @(negedge clk);
        tick();
        check("unpause_phase", phase, 3);
        check("unpause_frame", scene_frame, 5);
        ticks(15);
        check("s3_scene", scene_id, 3);

        // Scene 3 -> wrap to 0, latching a longer length on the way
        ticks(15);
        press_next();
        tick();
        check("s3_skip_phase", phase, 3);
        len_sel = 2'd1;
        ticks(15);
        check("wrap_scene", scene_id, 0);
        check("wrap_phase", phase, 1);
        len_sel = 2'd3;
        ticks(15);
        ticks(127);
        check("len128_frame", scene_frame, 127);
        check("len128_phase", phase, 2);
        tick();
        check("len128_end_phase", phase, 3);
        check("len128_end_frame", scene_frame, 127);

        // Reset mid fade-out
        ticks(8);
        check("pre_rst_fade",  fade_level, 7);
        check("pre_rst_phase", phase, 3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_phase", phase, 0);
        check("midrst_fade",  fade_level, 0);
        check("midrst_scene", scene_id, 0);
        check("midrst_frame", scene_frame, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demo_scene_sequencer.md
Name: demo_scene_sequencer

Overview:
- Frame-rate scheduler for the demo effect datapath.
- Steps through NUM_SCENES effect scenes; each scene runs FADE_IN -> RUN -> FADE_OUT.
- Drives scene select, per-scene frame counter and a fade level to the pixel pipeline.
- Advances once per video frame on frame_tick from the sync generator. Takes user controls from synchronised ui_in buttons.

Parameters:
- NUM_SCENES, 4: number of scenes; scene_id wraps modulo this value. Must be 2..4.
- FRAME_W, 10: width of the scene frame counter.
- FADE_STEPS, 16: fade-in/out length in frames. Power of two; fade_level is log2(FADE_STEPS) bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, active-low, synchronous
- ena  in  1  design enable; low freezes all state
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- btn_next  in  1  asynchronous button: skip to next scene
- btn_pause  in  1  asynchronous level: freeze sequencing while high
- len_sel  in  2  scene length select: 0=64, 1=128, 2=256, 3=512 frames
- scene_id  out  2  current scene index
- scene_frame  out  FRAME_W  frames elapsed in RUN for the current scene
- fade_level  out  4  0 = black, 15 = full brightness
- scene_start  out  1  one-cycle pulse when a new scene enters FADE_IN
- phase  out  2  FSM state encoding: IDLE=0, FADE_IN=1, RUN=2, FADE_OUT=3

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset values: phase=IDLE, scene_id=0, scene_frame=0, fade_level=0, scene_start=0. Synchroniser flops and next_pend are cleared.
- Reset asserted mid-scene returns to IDLE on that clock edge; no partial fade is retained.
- ena=0: every register holds. frame_tick pulses arriving during this time are lost.
- Buttons:
  - Each button passes through a 2-FF synchroniser.
  - btn_next uses rising-edge detect (3-cycle latency from pin) and sets next_pend.
  - next_pend is consumed only on a qualifying frame_tick.
- Qualifying tick: frame_tick=1 AND ena=1 AND synchronised pause=0.
  - While paused, ticks are ignored and next_pend is retained.
  - All FSM updates below happen only on qualifying ticks; outputs change on that same clock edge.
- IDLE: next tick -> FADE_IN. Pulse scene_start. Latch len_sel into scene_len.
- FADE_IN:
  - fade_level +1 per tick.
  - On the tick where fade_level reaches 15 -> RUN, with scene_frame=0.
  - If next_pend is set: go to FADE_OUT with fade_level held, and clear next_pend.
- RUN:
  - scene_frame +1 per tick.
  - When scene_frame == scene_len-1, or next_pend is set -> FADE_OUT; clear next_pend.
  - Both conditions on the same tick cause a single transition.
  - fade_level stays 15.
- FADE_OUT:
  - fade_level -1 per tick. next_pend is ignored and cleared.
  - On the tick where fade_level reaches 0: scene_id advances, scene_frame=0, scene_start pulses, len_sel is re-latched, then -> FADE_IN.
  - Advance rule: (scene_id+1) mod NUM_SCENES, with wrap 3->0 for NUM_SCENES=4.
- scene_start is high for exactly one clk cycle and is registered.
- Arithmetic:
  - Counters are unsigned.
  - scene_frame never exceeds 511; with FRAME_W=10 there is no overflow.
  - fade_level saturates and never wraps.

Optional Feature:
- Macro: DEMO_SCENE_SHUFFLE_EN.
- Defined:
  - An 8-bit Galois LFSR (taps 0xB8, reset seed 0x01) steps on every qualifying tick.
  - The next scene is lfsr[1:0] mod NUM_SCENES.
  - If that equals the current scene, use (current+1) mod NUM_SCENES instead, so a scene never repeats back-to-back.
- Undefined: the LFSR is absent and scenes advance sequentially.

Decomposition:
- Package demo_pkg holds:
  - phase enum: IDLE, FADE_IN, RUN, FADE_OUT
  - FADE_MAX=15
  - scene length lookup function: len_sel -> frame count
  - LFSR taps constant
- One sub-module: btn_sync_edge, a 2-FF synchroniser with optional rising-edge pulse output. Instantiated twice.

Test Plan:
- Reset, ena=1, len_sel=0, 16 ticks -> scene_start pulses once on the first tick; fade_level 1..15; phase=RUN after tick 16.
- Continue 64 ticks, then 15 more -> scene_frame counts 0..63; FADE_OUT after the 64th tick; fade_level reaches 0 after 15 ticks; scene_id=1; scene_start pulses.
- Pulse btn_next in RUN at scene_frame=10 -> FADE_OUT on the next tick, not earlier than 3 clks after the edge; scene_frame frozen at 11.
- Hold btn_pause across 20 ticks in RUN while pulsing btn_next -> all outputs constant. Release pause -> FADE_OUT on the first qualifying tick.
- Drive scene_id to 3 -> next scene_id=0. With DEMO_SCENE_SHUFFLE_EN, 50 scene changes never repeat the same id consecutively.
- Assert rst_n=0 for one clk mid FADE_OUT with fade_level=7 -> next cycle phase=IDLE, fade_level=0, scene_id=0.
